inst_stepper: RTL
=================

# inst_stepper

Upstream front end of the nexys3 calculator core: turns the raw step button and the 8 instruction switches into a clean instruction strobe. It synchronizes and debounces the button and latches the switch word on each accepted press. It then emits exactly one single-cycle `inst_vld` with a stable `inst_wd`, which the core decodes as PUSH/ADD/MULT/SEND. It sits between the board pins (`btnS`, `sw`) and the core's instruction decoder.

## Interface
Parameters:
- `DEB_CYCLES`, default 50000: clock cycles the synchronized button must stay stable before a level change is accepted (0.5 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default `$clog2(DEB_CYCLES)`: debounce counter width; derived, not overridden.

Ports:
- `clk` in 1: system clock, 100 MHz; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_in` in 1: raw step button, asynchronous to `clk`, bouncy.
- `sw_in` in 8: raw instruction switches, asynchronous, quasi-static.
- `inst_vld` out 1: one-cycle strobe per accepted press.
- `inst_wd` out 8: instruction word; updated only in the cycle `inst_vld` rises, held until the next strobe.
- `step_cnt` out 8: accepted-press count; present only with `INST_STEPPER_CNT_EN`.

## Operation
- Synchronization:
  - `btn_in` passes through 2 flops to give `btn_s`.
  - `sw_in` passes through 2 flops to give `sw_s`.
- FSM states:
  - IDLE: debounced low. If `btn_s`=1, go to PRESS_WAIT with cnt←0.
  - PRESS_WAIT:
    - If `btn_s`=0, go to IDLE (bounce rejected).
    - Otherwise, if cnt==DEB_CYCLES-1, go to HELD, set `inst_vld`←1 and `inst_wd`←`sw_s`.
    - Otherwise, cnt++.
  - HELD: debounced high. If `btn_s`=0, go to RELEASE_WAIT with cnt←0.
  - RELEASE_WAIT:
    - If `btn_s`=1, go to HELD with no new strobe.
    - Otherwise, if cnt==DEB_CYCLES-1, go to IDLE.
    - Otherwise, cnt++.
- `inst_vld` is a registered output and is cleared on every cycle it is not being set. It can never be high on two consecutive cycles.
- Holding the button indefinitely produces exactly one strobe. There is no auto-repeat.
- Reset value of every output is 0: `inst_vld`=0, `inst_wd`=8'h00, `step_cnt`=8'h00.
- On reset:
  - FSM enters HELD.
  - Sync flops clear to 0.
  - cnt clears to 0.
- Because reset enters HELD, the button must be seen debounced-low for DEB_CYCLES cycles before the first press is accepted. A button held through reset never fires.
- Reset asserted mid-PRESS_WAIT aborts the pending press; no strobe is issued.
- `sw_in` is sampled only at the accepting edge. Switch changes at any other time have no effect.

## Timing
- Let E be the first rising edge at which `btn_s`=1 while in IDLE.
  - `inst_vld` is high during the cycle after edge E+DEB_CYCLES.
  - From the raw `btn_in` rise, latency is DEB_CYCLES+3 cycles, ±1 cycle for metastability resolution.
- `inst_wd` changes in the same cycle `inst_vld` rises, and is stable for every later cycle until the next strobe.
- A glitch of fewer than DEB_CYCLES cycles in either direction never changes the debounced state.
- Minimum spacing between strobes is 2·DEB_CYCLES+2 cycles.

## Configuration
- `INST_STEPPER_CNT_EN` defined:
  - Port `step_cnt` exists.
  - It increments by 1, modulo 256, on every `inst_vld` cycle; 8'hFF wraps to 8'h00.
  - Reset value is 8'h00.
- `INST_STEPPER_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `nexys3_pkg` holds:
  - the FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT);
  - the opcode constants PUSH=2'b00, ADD=2'b01, MULT=2'b10, SEND=2'b11, which the core decoder also uses.
- One sub-module, `sync2`: a parameterized-width 2-flop synchronizer, instantiated once for the button and once for the switches.

## Test plan
All scenarios use DEB_CYCLES=16 unless noted.
- Clean press:
  - Stimulus: `sw_in`=8'b00_00_0100, `btn_in` high for 100 cycles after ≥16 low cycles following reset.
  - Response: exactly one `inst_vld` pulse, 19±1 cycles after the rise, with `inst_wd`=8'h04.
- Bounce rejection:
  - Stimulus: `btn_in` toggles every 5 cycles for 60 cycles, then stays low.
  - Response: no `inst_vld`; `inst_wd` unchanged.
- Hold and release bounce:
  - Stimulus: press held 500 cycles, then release with three 4-cycle high bounces.
  - Response: exactly one strobe.
- Reset mid-press:
  - Stimulus: assert `rst` at cycle 10 of PRESS_WAIT, then release `rst` with `btn_in` still high.
  - Response: no strobe until `btn_in` goes low for ≥16 cycles and is pressed again.
- Switch sampling:
  - Stimulus: `sw_in` changes from 8'h5B to 8'hC0 eight cycles after the press is accepted.
  - Response: `inst_wd`=8'h5B and it stays 8'h5B.
- `INST_STEPPER_CNT_EN`:
  - Stimulus: 257 accepted presses.
  - Response: `step_cnt` reads 8'h01; it read 8'h00 after press 256.

Source files
------------

// File: rtl/nexys3_pkg.sv
// Shared definitions for the nexys3 calculator core: step FSM states and the
// instruction opcodes the core decoder understands.
package nexys3_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } stepper_state_t;

    typedef logic [1:0] opcode_t;

    localparam opcode_t PUSH = 2'b00;
    localparam opcode_t ADD  = 2'b01;
    localparam opcode_t MULT = 2'b10;
    localparam opcode_t SEND = 2'b11;

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous board inputs.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inst_stepper.sv
// Step-button front end: synchronize, debounce, and emit one instruction strobe
// per accepted press. Optional press counter on step_cnt under INST_STEPPER_CNT_EN.
module inst_stepper
    import nexys3_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic [7:0] sw_in,
    output logic       inst_vld,
    output logic [7:0] inst_wd
`ifdef INST_STEPPER_CNT_EN
    ,
    output logic [7:0] step_cnt
`endif
);

    logic           btn_s;
    logic [7:0]     sw_s;
    stepper_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           cnt_last;
    logic           fire;

    sync2 #(.W(1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    sync2 #(.W(8)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d   (sw_in),
        .q   (sw_s)
    );

    assign cnt_last = (cnt_q == CNT_W'(DEB_CYCLES - 1));

    // Reset lands in HELD so a button held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HELD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (btn_s) state_d = PRESS_WAIT;
            PRESS_WAIT: begin
                if (!btn_s)        state_d = IDLE;
                else if (cnt_last) state_d = HELD;
            end
            HELD:         if (!btn_s) state_d = RELEASE_WAIT;
            RELEASE_WAIT: begin
                if (btn_s)         state_d = HELD;
                else if (cnt_last) state_d = IDLE;
            end
            default:      state_d = HELD;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        fire  = 1'b0;
        case (state_q)
            PRESS_WAIT: begin
                if (btn_s && cnt_last)  fire  = 1'b1;
                else if (btn_s)         cnt_d = cnt_q + CNT_W'(1);
            end
            RELEASE_WAIT: begin
                if (!btn_s && !cnt_last) cnt_d = cnt_q + CNT_W'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_vld <= 1'b0;
            inst_wd  <= 8'h00;
        end else begin
            inst_vld <= fire;
            if (fire) inst_wd <= sw_s;
        end
    end

`ifdef INST_STEPPER_CNT_EN
    // Counter advances together with the strobe edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       step_cnt <= 8'h00;
        else if (fire) step_cnt <= step_cnt + 8'd1;
    end
`endif

endmodule
